// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared types and constants for the sort_E1 sorter and its stage wrappers
package sort_pkg;

  localparam int SORT_DATA_W    = 8;
  localparam int SORT_NUM_IN    = 16;
  localparam int SORT_ISSUE_GAP = 6;
  localparam int SORT_E1_LAT    = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_WAIT,
    S_GAP,
    S_DRAIN,
    S_DONE
  } sched_state_t;

endpackage

// File: rtl/sort_e1_sched.sv
// rtl/sort_e1_sched.sv - frame sequencer feeding sort words to the sort_E1 top-5 sorter
// Optional SORT_E1_SCHED_PERF_EN adds a saturating frame_cycles counter output.
module sort_e1_sched
  import sort_pkg::*;
#(
  parameter int DATA_W    = SORT_DATA_W,
  parameter int NUM_IN    = SORT_NUM_IN,
  parameter int CNT_W     = 16,
  parameter int ISSUE_GAP = SORT_ISSUE_GAP,
  parameter int E1_LAT    = SORT_E1_LAT
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       cfg_start,
  input  logic                       cfg_abort,
  input  logic [CNT_W-1:0]           cfg_num_words,
  input  logic                       in_valid,
  input  logic [2*DATA_W*NUM_IN-1:0] in_data,
  output logic                       in_ready,
  output logic [2*DATA_W*NUM_IN-1:0] sort_in,
  output logic                       sort_en,
  output logic                       last_sort,
  output logic                       sorter_clr,
  input  logic                       E1_sort_en,
  input  logic                       E1_last_sort,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       err_seq
`ifdef SORT_E1_SCHED_PERF_EN
  ,
  output logic [31:0]                frame_cycles
`endif
);

  localparam int WORD_W = 2 * DATA_W * NUM_IN;
  localparam int GAP_W  = $clog2(ISSUE_GAP);
  // Legal traffic never has more than E1_LAT/ISSUE_GAP+1 words outstanding.
  localparam int INFL_W = $clog2(E1_LAT / ISSUE_GAP + 2) + 1;

  sched_state_t      state_q, state_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [INFL_W-1:0] inflight_q, inflight_d;
  logic [WORD_W-1:0] sort_in_q, sort_in_d;
  logic              sort_en_q, sort_en_d;
  logic              last_sort_q, last_sort_d;
  logic              sorter_clr_q, sorter_clr_d;
  logic              frame_done_q, frame_done_d;
  logic              err_seq_q, err_seq_d;
  logic              hs;

  assign in_ready   = (state_q == S_WAIT);
  assign busy       = (state_q != S_IDLE);
  assign sort_in    = sort_in_q;
  assign sort_en    = sort_en_q;
  assign last_sort  = last_sort_q;
  assign sorter_clr = sorter_clr_q;
  assign frame_done = frame_done_q;
  assign err_seq    = err_seq_q;

  assign hs = in_ready && in_valid && !cfg_abort;

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    gap_cnt_d    = gap_cnt_q;
    inflight_d   = inflight_q;
    sort_in_d    = sort_in_q;
    sort_en_d    = 1'b0;
    last_sort_d  = 1'b0;
    sorter_clr_d = 1'b0;
    frame_done_d = 1'b0;
    err_seq_d    = err_seq_q;

    if (hs && !E1_sort_en) begin
      inflight_d = inflight_q + INFL_W'(1);
    end else if (!hs && E1_sort_en) begin
      if (inflight_q == '0) begin
        err_seq_d = 1'b1;
      end else begin
        inflight_d = inflight_q - INFL_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          err_seq_d   = 1'b0;
          remaining_d = cfg_num_words;
          if (cfg_num_words == '0) begin
            state_d      = S_DONE;
            frame_done_d = 1'b1;
          end else begin
            state_d      = S_CLR;
            sorter_clr_d = 1'b1;
          end
        end
      end
      S_CLR: state_d = S_WAIT;
      S_WAIT: begin
        if (hs) begin
          sort_in_d   = in_data;
          sort_en_d   = 1'b1;
          last_sort_d = (remaining_q == CNT_W'(1));
          remaining_d = remaining_q - CNT_W'(1);
          gap_cnt_d   = GAP_W'(ISSUE_GAP - 1);
          state_d     = S_GAP;
        end
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q - GAP_W'(1);
        if (gap_cnt_q <= GAP_W'(1)) begin
          state_d = (remaining_q != '0) ? S_WAIT : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (E1_sort_en && E1_last_sort) begin
          state_d      = S_DONE;
          frame_done_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort flushes the sorter and drops the frame without a completion pulse.
    if (cfg_abort) begin
      state_d      = S_IDLE;
      remaining_d  = '0;
      gap_cnt_d    = '0;
      inflight_d   = '0;
      sort_en_d    = 1'b0;
      last_sort_d  = 1'b0;
      frame_done_d = 1'b0;
      sorter_clr_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= S_IDLE;
      remaining_q  <= '0;
      gap_cnt_q    <= '0;
      inflight_q   <= '0;
      sort_in_q    <= '0;
      sort_en_q    <= 1'b0;
      last_sort_q  <= 1'b0;
      sorter_clr_q <= 1'b0;
      frame_done_q <= 1'b0;
      err_seq_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      gap_cnt_q    <= gap_cnt_d;
      inflight_q   <= inflight_d;
      sort_in_q    <= sort_in_d;
      sort_en_q    <= sort_en_d;
      last_sort_q  <= last_sort_d;
      sorter_clr_q <= sorter_clr_d;
      frame_done_q <= frame_done_d;
      err_seq_q    <= err_seq_d;
    end
  end

`ifdef SORT_E1_SCHED_PERF_EN
  logic [31:0] frame_cycles_q, frame_cycles_d;

  // Counts every non-idle cycle of the frame, so the value covers S_CLR through S_DONE.
  always_comb begin
    frame_cycles_d = frame_cycles_q;
    if (state_q == S_IDLE && cfg_start && !cfg_abort) begin
      frame_cycles_d = '0;
    end else if (state_q != S_IDLE && frame_cycles_q != 32'hFFFF_FFFF) begin
      frame_cycles_d = frame_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_cycles_q <= '0;
    end else begin
      frame_cycles_q <= frame_cycles_d;
    end
  end

  assign frame_cycles = frame_cycles_q;
`endif

endmodule
